// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared types, constants and helpers for the CIC gain normaliser
package cic_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_CALC,
        ST_FIND,
        ST_IDLE
    } gain_state_t;

    localparam int N_MIN   = 2;
    localparam int N_MAX   = 8;
    localparam int SHIFT_W = 5;
    localparam int K_W     = 4;
    localparam int P_W_MAX = 32;

    // Product register must hold R^(N-1) for the widest rate, and fit the bitlen argument.
    function automatic bit params_ok(input int n, input int rw, input int maxbitgain);
        return (n >= N_MIN) && (n <= N_MAX) && (maxbitgain >= (n - 1) * rw)
            && (maxbitgain + 1 <= P_W_MAX);
    endfunction

    function automatic logic [SHIFT_W-1:0] bitlen(input logic [P_W_MAX-1:0] x);
        logic [SHIFT_W-1:0] r;
        r = '0;
        for (int i = 0; i < P_W_MAX; i++) begin
            if (x[i]) r = SHIFT_W'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_int_gain_norm_if.sv
// rtl/cic_int_gain_norm_if.sv - strobed sample bus into and out of the gain normaliser
interface cic_int_gain_norm_if #(
    parameter int bw         = 16,
    parameter int maxbitgain = 24
);
    logic                       strobe_in;
    logic [bw+maxbitgain-1:0]   signal_in;
    logic                       strobe_out;
    logic [bw-1:0]              signal_out;
    logic                       overflow;

    modport master (
        output strobe_in, signal_in,
        input  strobe_out, signal_out, overflow
    );

    modport slave (
        input  strobe_in, signal_in,
        output strobe_out, signal_out, overflow
    );
endinterface

// File: rtl/cic_int_gain_norm_bitgain.sv
// rtl/cic_int_gain_norm_bitgain.sv - sequential engine computing ceil((N-1)*log2(R))
module cic_bitgain_calc
    import cic_pkg::*;
#(
    parameter int N          = 4,
    parameter int rw         = 8,
    parameter int maxbitgain = 24
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [rw-1:0]      rate_i,
    output logic [SHIFT_W-1:0] shift_o,
    output logic               busy_o
);
    localparam int PW = maxbitgain + 1;

    gain_state_t        state_q;
    logic [rw-1:0]      rate_cur_q;
    logic [PW-1:0]      p_q;
    logic [K_W-1:0]     k_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               busy_q;

    logic [rw:0]        r_plus_d;
    logic [PW-1:0]      p_d;

    always_comb begin
        r_plus_d = {1'b0, rate_cur_q} + (rw+1)'(1);
        p_d      = p_q * PW'(r_plus_d);
    end

    // A rate change restarts the engine from any state, overriding completion.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_INIT;
            rate_cur_q <= '0;
            p_q        <= PW'(1);
            k_q        <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b1;
        end else if (state_q == ST_INIT || rate_i != rate_cur_q) begin
            state_q    <= ST_CALC;
            rate_cur_q <= rate_i;
            p_q        <= PW'(1);
            k_q        <= '0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_CALC: begin
                    p_q <= p_d;
                    k_q <= k_q + K_W'(1);
                    if (k_q == K_W'(N - 2)) state_q <= ST_FIND;
                end
                ST_FIND: begin
                    shift_q <= bitlen(P_W_MAX'(p_q - PW'(1)));
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign shift_o = shift_q;
    assign busy_o  = busy_q;
endmodule

// File: rtl/cic_int_gain_norm.sv
// rtl/cic_int_gain_norm.sv - CIC interpolator gain normaliser: round, shift, saturate
module cic_int_gain_norm
    import cic_pkg::*;
#(
    parameter int bw         = 16,
    parameter int N          = 4,
    parameter int rw         = 8,
    parameter int maxbitgain = 24
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [rw-1:0]      rate_i,
    cic_int_gain_norm_if.slave bus,
    output logic               busy_o,
    output logic [SHIFT_W-1:0] shift_o
);
    localparam int W  = bw + maxbitgain;
    localparam int WS = W + 1;
    localparam logic signed [WS-1:0] MAXV = {{(WS-bw+1){1'b0}}, {(bw-1){1'b1}}};
    localparam logic signed [WS-1:0] MINV = {{(WS-bw+1){1'b1}}, {(bw-1){1'b0}}};

    if (!params_ok(N, rw, maxbitgain)) begin : g_param_check
        $error("cic_int_gain_norm: illegal N/rw/maxbitgain combination");
    end

    logic               busy_w;
    logic [SHIFT_W-1:0] shift_w;

    cic_bitgain_calc #(.N(N), .rw(rw), .maxbitgain(maxbitgain)) u_bitgain (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .rate_i  (rate_i),
        .shift_o (shift_w),
        .busy_o  (busy_w)
    );

    logic                 v1_q, z1_q, v2_q, ovf_q;
    logic signed [WS-1:0] s1_q;
    logic [bw-1:0]        sig_q;

    logic signed [WS-1:0] rc, s1_d, t;
    logic                 hi, lo;
    logic [bw-1:0]        sig_d;
    logic                 ovf_d;

    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    always_comb begin
        rc    = (shift_w != '0) ? (WS'(1) << (shift_w - SHIFT_W'(1))) : '0;
        s1_d  = $signed({bus.signal_in[W-1], bus.signal_in}) + rc;
        t     = s1_q >>> shift_w;
        hi    = (t > MAXV);
        lo    = (t < MINV);
        sig_d = z1_q ? '0 : (hi ? MAXV[bw-1:0] : (lo ? MINV[bw-1:0] : t[bw-1:0]));
        ovf_d = v1_q & ~z1_q & (hi | lo);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            v1_q  <= 1'b0;
            z1_q  <= 1'b0;
            s1_q  <= '0;
            v2_q  <= 1'b0;
            sig_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            v1_q <= bus.strobe_in;
            if (bus.strobe_in) begin
                s1_q <= s1_d;
                z1_q <= busy_w;
            end
            v2_q  <= v1_q;
            ovf_q <= ovf_d;
            if (v1_q) sig_q <= sig_d;
        end
    end

    assign bus.strobe_out = v2_q;
    assign bus.signal_out = sig_q;
    assign bus.overflow   = ovf_q;
    assign busy_o         = busy_w;
    assign shift_o        = shift_w;
endmodule
